// File: rtl/nonlinear_round_cipher.sv
// Iterative keyed nonlinear round cipher: ROUNDS rounds per N-bit block, one round per clock.
// Optional macro NLRC_BLOCK_COUNT_EN adds a 16-bit count of completed output handshakes.
module nonlinear_round_cipher #(
    parameter int N      = 8,
    parameter int ROUNDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] data_in,
    input  logic [N-1:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] data_out,
    output logic         busy
`ifdef NLRC_BLOCK_COUNT_EN
    ,
    output logic [15:0]  block_count
`endif
);

    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_e;

    fsm_e          fsm_q;
    logic [N-1:0]  state_q;
    logic [N-1:0]  key_q;
    logic [RW-1:0] rnd_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;

    logic [N-1:0]  rk_d;
    logic [N-1:0]  t_d;
    logic [N-1:0]  state_d;
    int            rot_amt;

    // Round key is the captured key rotated left by (rnd mod N), XORed with the round index.
    always_comb begin
        rot_amt = int'(rnd_q) % N;
        rk_d    = N'(({key_q, key_q} << rot_amt) >> N) ^ N'(rnd_q);
        t_d     = state_q ^ rk_d;
        state_d = t_d;
        for (int i = 0; i < N; i++) begin
            state_d[i] = t_d[i] ^ (t_d[(i + 1) % N] & rk_d[i]);
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order in this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            key_q       <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= data_in;
                        key_q      <= key;
                        rnd_q      <= '0;
                        fsm_q      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= state_d;
                    if (rnd_q == LAST_RND) begin
                        // Counter parks at zero so it never exceeds ROUNDS-1.
                        rnd_q       <= '0;
                        fsm_q       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_out  = state_q;

`ifdef NLRC_BLOCK_COUNT_EN
    logic [15:0] block_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            block_count_q <= '0;
        end else if (out_valid_q && out_ready) begin
            block_count_q <= block_count_q + 16'd1;
        end
    end

    assign block_count = block_count_q;
`endif

endmodule

// File: tb/tb_nonlinear_round_cipher.sv
// Randomized self-checking bench for nonlinear_round_cipher (ROUNDS=4 and ROUNDS=1 instances)
// against a bit-vector reference model; exercises NLRC_BLOCK_COUNT_EN when defined.
module tb_nonlinear_round_cipher;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid  [2];
    logic         in_ready  [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic         busy      [2];
    logic [N-1:0] data_in   [2];
    logic [N-1:0] key       [2];
    logic [N-1:0] data_out  [2];
`ifdef NLRC_BLOCK_COUNT_EN
    logic [15:0]  block_count [2];
`endif

    int checks = 0;
    int errors = 0;

    nonlinear_round_cipher #(.N(N), .ROUNDS(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .data_in(data_in[0]), .key(key[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .data_out(data_out[0]), .busy(busy[0])
`ifdef NLRC_BLOCK_COUNT_EN
        , .block_count(block_count[0])
`endif
    );

    nonlinear_round_cipher #(.N(N), .ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .data_in(data_in[1]), .key(key[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .data_out(data_out[1]), .busy(busy[1])
`ifdef NLRC_BLOCK_COUNT_EN
        , .block_count(block_count[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: nr rounds of the keyed round function, computed on whole bytes.
    function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] k, input int nr);
        logic [7:0] s;
        logic [7:0] rk;
        logic [7:0] t;
        int         kk;
        int         sh;
        s  = x;
        kk = int'(k);
        for (int r = 0; r < nr; r++) begin
            sh = r % 8;
            rk = 8'((((kk << sh) | (kk >> (8 - sh))) & 255) ^ (r & 255));
            t  = s ^ rk;
            s  = t ^ ({t[0], t[7:1]} & rk);
        end
        return s;
    endfunction

    function automatic int rounds_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic run_block(input int d, input logic [7:0] pt, input logic [7:0] k,
                             input int hold, input bit scramble);
        int         nr;
        int         lat;
        int         busy_cnt;
        logic [7:0] exp;
        nr  = rounds_of(d);
        lat = 0;
        while (!in_ready[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("in_ready_idle", 32'(in_ready[d]), 1);
        data_in[d]  = pt;
        key[d]      = k;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        busy_cnt = 0;
        lat      = 0;
        while (!out_valid[d] && lat < 50) begin
            if (busy[d]) busy_cnt++;
            check("round_state", 32'(data_out[d]), 32'(model(pt, k, lat)));
            check("in_ready_run", 32'(in_ready[d]), 0);
            if (scramble) begin
                data_in[d]  = 8'($urandom);
                key[d]      = 8'($urandom);
                in_valid[d] = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid[d] = 1'b0;
        check("latency", 32'(lat), 32'(nr));
        check("busy_cycles", 32'(busy_cnt), 32'(nr));
        exp = model(pt, k, nr);
        check("data_out", 32'(data_out[d]), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            if (scramble) begin
                data_in[d]  = 8'($urandom);
                key[d]      = 8'($urandom);
                in_valid[d] = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid[d]), 1);
            check("hold_data", 32'(data_out[d]), 32'(exp));
            check("hold_ready", 32'(in_ready[d]), 0);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check("drain_valid", 32'(out_valid[d]), 0);
        check("drain_ready", 32'(in_ready[d]), 1);
    endtask

    task automatic check_reset_state(input int d);
        check("rst_in_ready", 32'(in_ready[d]), 1);
        check("rst_out_valid", 32'(out_valid[d]), 0);
        check("rst_busy", 32'(busy[d]), 0);
        check("rst_data_out", 32'(data_out[d]), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         seen;
        logic [7:0] pt;
        logic [7:0] k;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            data_in[d]   = '0;
            key[d]       = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state(0);
        check_reset_state(1);

        // Single-round vectors
        run_block(1, 8'h0F, 8'h01, 0, 1'b0);
        run_block(1, 8'h00, 8'hFF, 0, 1'b0);
        run_block(1, 8'hFF, 8'h00, 0, 1'b0);

        // Four rounds of zero data / zero key: states 00, 01, 03, 00
        run_block(0, 8'h00, 8'h00, 0, 1'b0);

        // Backpressure for 10 cycles with inputs churning
        run_block(0, 8'($urandom), 8'($urandom), 10, 1'b1);

        // Abort a block after two rounds
        pt = 8'($urandom);
        k  = 8'($urandom);
        data_in[0]  = pt;
        key[0]      = k;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state(0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid[0]) seen = 1'b1;
        end
        check("abort_no_output", 32'(seen), 0);
        run_block(0, 8'($urandom), 8'($urandom), 1, 1'b0);

`ifdef NLRC_BLOCK_COUNT_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("count_reset", 32'(block_count[0]), 0);
        repeat (3) run_block(0, 8'($urandom), 8'($urandom), 0, 1'b0);
        check("count_three", 32'(block_count[0]), 3);
        force dut1.block_count_q = 16'hFFFE;
        #1;
        release dut1.block_count_q;
        run_block(1, 8'($urandom), 8'($urandom), 0, 1'b0);
        check("count_ffff", 32'(block_count[1]), 32'h0000FFFF);
        run_block(1, 8'($urandom), 8'($urandom), 0, 1'b0);
        check("count_wrap", 32'(block_count[1]), 0);
`endif

        for (int i = 0; i < 12; i++) begin
            run_block(0, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b1);
            run_block(1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
